chunked_serial_adder: RTL
=========================

# chunked_serial_adder

Multi-cycle wide adder that computes a WIDTH-bit sum by sequencing a single CHUNK-bit `ripple_carry_adder` over NUM_CHUNKS = WIDTH/CHUNK cycles, registering the carry between chunks. It sits directly around the ripple-carry adder stage and consumes its `S`, `cout` and `prev_cout` outputs. It serves vector-lane arithmetic where area matters more than latency. Operands arrive and results leave on valid/ready handshakes.

## Interface
- WIDTH, 32, total operand width; must be a multiple of CHUNK.
- CHUNK, 8, width of the internal `ripple_carry_adder`; 1 ≤ CHUNK ≤ WIDTH.
- clk  input  1  clock; all state updates on the rising edge.
- rst  input  1  reset, asynchronous, active-high.
- in_valid  input  1  operand beat valid.
- in_ready  output  1  block can accept operands; high only in IDLE.
- a  input  WIDTH  operand A.
- b  input  WIDTH  operand B.
- cin  input  1  carry-in to bit 0.
- sub  input  1  subtract request; present only when CHUNKED_ADDER_SUB_EN is defined.
- out_valid  output  1  result valid; high only in DONE.
- out_ready  input  1  downstream accepts the result.
- sum  output  WIDTH  result.
- cout  output  1  carry out of bit WIDTH-1.
- overflow  output  1  signed overflow, equal to the carry into the MSB XOR the carry out of the MSB.

## Operation
- FSM states are IDLE, BUSY and DONE. Internal registers are a_q, b_q, carry_q, idx (clog2(NUM_CHUNKS) bits, minimum 1), sum_q, cout_q and ovf_q.
- IDLE: in_ready=1. On in_valid && in_ready:
  - Capture a into a_q and b into b_q (b_q = ~b when subtracting).
  - Set carry_q = cin (forced to 1 when subtracting).
  - Set idx=0 and go to BUSY.
- BUSY: the adder gets A=a_q[idx*CHUNK +: CHUNK], B=b_q[idx*CHUNK +: CHUNK] and cin=carry_q. Each cycle:
  - Write the adder's S into sum_q[idx*CHUNK +: CHUNK].
  - Load the adder's cout into carry_q.
  - Increment idx.
- On the BUSY cycle with idx == NUM_CHUNKS-1:
  - Set cout_q = adder cout.
  - Set ovf_q = adder prev_cout XOR adder cout.
  - Go to DONE.
- DONE: out_valid=1. sum, cout and overflow are driven from sum_q, cout_q and ovf_q. When out_ready is high, go to IDLE.
- Arithmetic is modulo 2^WIDTH and there is no saturation. The sum bits not yet written keep their previous values but are never exposed while out_valid=0.
- in_valid is ignored outside IDLE. Inputs are sampled only on the accepting edge, so a/b/cin may change freely afterwards.
- A simultaneous out_ready in DONE and in_valid does not give a same-cycle accept. in_ready rises in the cycle after the DONE→IDLE transition.

## Timing
- Reset (async assert, takes effect immediately):
  - state=IDLE, so in_ready=1 and out_valid=0.
  - sum=0, cout=0, overflow=0, idx=0, carry_q=0.
  - Handshakes sampled while rst=1 are discarded.
- Reset in the middle of BUSY or DONE aborts the operation with no result emitted. The first accept is possible on the first edge after rst deasserts.
- Latency: out_valid rises NUM_CHUNKS cycles after the accepting edge (4 for 32/8, 1 for CHUNK=WIDTH).
- Minimum initiation interval is NUM_CHUNKS+2 cycles (IDLE, NUM_CHUNKS×BUSY, DONE).
- Backpressure: while out_valid && !out_ready, sum, cout and overflow are held bit-stable.
- The carry path per cycle is one CHUNK-bit ripple. There is no combinational path from any input to any output except in_ready/out_valid, which are derived from state.

## Configuration
- CHUNKED_ADDER_SUB_EN defined:
  - The `sub` port exists.
  - On accept with sub=1, b_q=~b and carry_q=1, giving sum = a - b and ignoring cin.
  - cout=1 means no borrow.
- CHUNKED_ADDER_SUB_EN undefined:
  - There is no `sub` port and the block is add-only: b_q=b, carry_q=cin.

## Test plan
- WIDTH=32/CHUNK=8, a=0xFFFFFFFF, b=0x00000001, cin=0 → sum=0x00000000, cout=1, overflow=0; out_valid exactly 4 cycles after accept.
- a=0x7FFFFFFF, b=0x00000001, cin=0 → sum=0x80000000, cout=0, overflow=1.
- a=0x000000FF, b=0, cin=1 → sum=0x00000100, which checks the carry crossing the chunk boundary.
- Result in DONE with out_ready held low for 3 cycles → sum, cout and overflow stable, in_ready=0, out_valid=1. Then out_ready=1 → IDLE, and in_ready=1 on the next cycle.
- Assert rst after 2 BUSY cycles → out_valid=0, sum=0, in_ready=1 immediately. A new op a=3, b=4 accepted after reset → sum=0x00000007 with no stale chunks.
- With CHUNKED_ADDER_SUB_EN: sub=1, a=5, b=7 → sum=0xFFFFFFFE, cout=0, overflow=0. Then sub=1, a=0x80000000, b=1 → sum=0x7FFFFFFF, overflow=1.

Source files
------------

// File: rtl/chunked_serial_adder.sv
// ----------------------------------------------------------------------------
// chunked_serial_adder
//
// Multi-cycle wide adder. A WIDTH-bit sum is produced by sequencing one
// CHUNK-bit ripple_carry_adder over NUM_CHUNKS = WIDTH/CHUNK cycles. The carry
// between chunks is held in a register. Operands are accepted on a
// valid/ready handshake, and the result is handed off on another one.
//
// Parameters:
//   WIDTH  total operand width; must be a multiple of CHUNK
//   CHUNK  width of the internal ripple-carry adder (1 <= CHUNK <= WIDTH)
//
// Ports:
//   clk        clock; all state updates on the rising edge
//   rst        asynchronous, active-high reset
//   in_valid   operand beat valid
//   in_ready   block can accept operands (high only in IDLE)
//   a, b       WIDTH-bit operands
//   cin        carry-in to bit 0
//   sub        subtract request (present only with CHUNKED_ADDER_SUB_EN)
//   out_valid  result valid (high only in DONE)
//   out_ready  downstream accepts the result
//   sum        WIDTH-bit result
//   cout       carry out of bit WIDTH-1 (with subtraction: 1 = no borrow)
//   overflow   signed overflow (carry into MSB XOR carry out of MSB)
//
// Optional feature macro: CHUNKED_ADDER_SUB_EN
//   When defined, the 'sub' port exists. Subtraction stores ~b and forces the
//   initial carry to 1. When undefined, the block is add-only.
//
// Contents: ripple_carry_adder (the per-chunk stage), chunked_serial_adder.
// ----------------------------------------------------------------------------

// ----------------------------------------------------------------------------
// ripple_carry_adder
//
// Plain N-bit ripple-carry adder.
//
// Ports:
//   A, B       N-bit addends
//   cin        carry into bit 0
//   S          N-bit sum
//   cout       carry out of bit N-1
//   prev_cout  carry into bit N-1; needed for signed-overflow detection
// ----------------------------------------------------------------------------
module ripple_carry_adder #(
    parameter int N = 8
) (
    input  logic [N-1:0] A,
    input  logic [N-1:0] B,
    input  logic         cin,
    output logic [N-1:0] S,
    output logic         cout,
    output logic         prev_cout
);

    logic [N:0] carry;

    always_comb begin
        carry    = '0;
        S        = '0;
        carry[0] = cin;
        for (int i = 0; i < N; i++) begin
            S[i]         = A[i] ^ B[i] ^ carry[i];
            carry[i + 1] = (A[i] & B[i]) | (carry[i] & (A[i] ^ B[i]));
        end
    end

    assign cout      = carry[N];
    // With N=1 this is simply cin, which is the carry into the only bit.
    assign prev_cout = carry[N - 1];

endmodule

module chunked_serial_adder #(
    parameter int WIDTH = 32,
    parameter int CHUNK = 8
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic             cin,
`ifdef CHUNKED_ADDER_SUB_EN
    input  logic             sub,
`endif
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] sum,
    output logic             cout,
    output logic             overflow
);

    localparam int NUM_CHUNKS = WIDTH / CHUNK;
    localparam int IDX_W      = (NUM_CHUNKS > 1) ? $clog2(NUM_CHUNKS) : 1;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        BUSY = 2'd1,
        DONE = 2'd2
    } state_t;

    state_t state_q, state_d;

    logic [WIDTH-1:0] a_q, a_d;
    logic [WIDTH-1:0] b_q, b_d;
    logic             carry_q, carry_d;
    logic [IDX_W-1:0] idx_q, idx_d;
    logic [WIDTH-1:0] sum_q, sum_d;
    logic             cout_q, cout_d;
    logic             ovf_q, ovf_d;

    logic             accept;
    logic             last_chunk;
    logic             sub_eff;

    logic [CHUNK-1:0] chunk_a;
    logic [CHUNK-1:0] chunk_b;
    logic [CHUNK-1:0] rca_s;
    logic             rca_cout;
    logic             rca_prev_cout;

`ifdef CHUNKED_ADDER_SUB_EN
    assign sub_eff = sub;
`else
    assign sub_eff = 1'b0;
`endif

    assign accept     = (state_q == IDLE) && in_valid;
    assign last_chunk = (idx_q == IDX_W'(NUM_CHUNKS - 1));

    // Select the operand chunk that idx points at. A compare-per-chunk mux
    // avoids a variable-width part-select on a multiplied index.
    always_comb begin
        chunk_a = '0;
        chunk_b = '0;
        for (int i = 0; i < NUM_CHUNKS; i++) begin
            if (idx_q == IDX_W'(i)) begin
                chunk_a = a_q[i*CHUNK +: CHUNK];
                chunk_b = b_q[i*CHUNK +: CHUNK];
            end
        end
    end

    ripple_carry_adder #(
        .N (CHUNK)
    ) u_rca (
        .A         (chunk_a),
        .B         (chunk_b),
        .cin       (carry_q),
        .S         (rca_s),
        .cout      (rca_cout),
        .prev_cout (rca_prev_cout)
    );

    // State register
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // Next-state logic. A DONE->IDLE hop always takes one edge, so a result
    // handoff and a new accept can never land on the same edge.
    always_comb begin
        state_d = state_q;
        unique case (state_q)
            IDLE: if (in_valid)   state_d = BUSY;
            BUSY: if (last_chunk) state_d = DONE;
            DONE: if (out_ready)  state_d = IDLE;
            default:              state_d = IDLE;
        endcase
    end

    // Output logic. The result outputs are only exposed in DONE, so chunks of
    // a partly computed sum never reach the port.
    always_comb begin
        in_ready  = (state_q == IDLE);
        out_valid = (state_q == DONE);
        sum       = '0;
        cout      = 1'b0;
        overflow  = 1'b0;
        if (state_q == DONE) begin
            sum      = sum_q;
            cout     = cout_q;
            overflow = ovf_q;
        end
    end

    // Datapath next values. Operands are captured once on accept. Each BUSY
    // cycle then retires one chunk and moves the carry into carry_q.
    always_comb begin
        a_d     = a_q;
        b_d     = b_q;
        carry_d = carry_q;
        idx_d   = idx_q;
        sum_d   = sum_q;
        cout_d  = cout_q;
        ovf_d   = ovf_q;

        if (accept) begin
            a_d     = a;
            b_d     = sub_eff ? ~b : b;
            carry_d = sub_eff | cin;
            idx_d   = '0;
        end else if (state_q == BUSY) begin
            for (int i = 0; i < NUM_CHUNKS; i++) begin
                if (idx_q == IDX_W'(i)) begin
                    sum_d[i*CHUNK +: CHUNK] = rca_s;
                end
            end
            carry_d = rca_cout;
            idx_d   = idx_q + IDX_W'(1);
            if (last_chunk) begin
                cout_d = rca_cout;
                ovf_d  = rca_prev_cout ^ rca_cout;
            end
        end
    end

    // Datapath registers
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            a_q     <= '0;
            b_q     <= '0;
            carry_q <= 1'b0;
            idx_q   <= '0;
            sum_q   <= '0;
            cout_q  <= 1'b0;
            ovf_q   <= 1'b0;
        end else begin
            a_q     <= a_d;
            b_q     <= b_d;
            carry_q <= carry_d;
            idx_q   <= idx_d;
            sum_q   <= sum_d;
            cout_q  <= cout_d;
            ovf_q   <= ovf_d;
        end
    end

endmodule
